// File: rtl/fb_arb_pkg.sv
`default_nettype none
// ============================================================================
// Module      : fb_arb_pkg
// Description : Shared types and constants for the frame-buffer read arbiter.
//               - owner tags carried alongside each RAM read;
//               - FSM state encodings;
//               - default frame-buffer geometry.
// Revision    : 1.0 - initial release
// ============================================================================
package fb_arb_pkg;

  // Owner of a read that is in flight through the RAM read pipeline
  typedef enum logic [1:0] {
    OWN_NONE = 2'd0,
    OWN_DISP = 2'd1,
    OWN_AUX  = 2'd2
  } own_t;

  // Aux burst FSM encodings
  localparam logic [1:0] c_ST_IDLE  = 2'd0;
  localparam logic [1:0] c_ST_RUN   = 2'd1;
  localparam logic [1:0] c_ST_DRAIN = 2'd2;

  // 320x240 RGB565 frame; the last word address is where bursts wrap to 0
  localparam int unsigned c_FB_WORDS_DEFAULT = 76800;
  localparam int unsigned c_FB_LAST_DEFAULT  = c_FB_WORDS_DEFAULT - 1;

endpackage
`default_nettype wire

// File: rtl/fb_arb_tag_pipe.sv
`default_nettype none
// ============================================================================
// Module      : fb_arb_tag_pipe
// Description : RD_LAT-deep shift register of read owner tags. The tag leaving
//               the last stage lines up with the RAM data for that read.
// Ports       : mclk, rst_n     - clock, async active-low reset
//               tag_in          - owner of the read issued this cycle
//               tag_out         - owner of the data on ram_doutb this cycle
//               aux_pending     - an aux read is still in flight beyond the
//                                 data currently being delivered
// Revision    : 1.0 - initial release
// ============================================================================
module fb_arb_tag_pipe
  import fb_arb_pkg::*;
#(
  parameter int RD_LAT = 1
) (
  input  logic mclk,
  input  logic rst_n,
  input  own_t tag_in,
  output own_t tag_out,
  output logic aux_pending
);

  own_t r_stage [RD_LAT];

  always_ff @(posedge mclk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < RD_LAT; i++) r_stage[i] <= OWN_NONE;
    end else begin
      r_stage[0] <= tag_in;
      for (int i = 1; i < RD_LAT; i++) r_stage[i] <= r_stage[i-1];
    end
  end

  assign tag_out = r_stage[RD_LAT-1];

  // The output stage is excluded: its data is consumed this cycle, so a burst
  // may finish draining in the same cycle its last word is delivered.
  generate
    if (RD_LAT == 1) begin : g_lat_one
      assign aux_pending = 1'b0;
    end else begin : g_lat_multi
      logic w_pend;
      always_comb begin
        w_pend = 1'b0;
        for (int i = 0; i < RD_LAT - 1; i++) begin
          if (r_stage[i] == OWN_AUX) w_pend = 1'b1;
        end
      end
      assign aux_pending = w_pend;
    end
  endgenerate

endmodule
`default_nettype wire

// File: rtl/fb_read_arbiter.sv
`default_nettype none
// ============================================================================
// Module      : fb_read_arbiter
// Description : Shares the frame-buffer RAM read port between the VGA display
//               (absolute priority, fixed latency) and an aux burst engine
//               that only uses cycles the display leaves idle.
// Ports       : mclk, rst_n                      - clock, async active-low reset
//               disp_req/disp_addr               - display read request
//               disp_rdata/disp_rvalid           - display read return
//               aux_cmd_valid/ready/addr/len     - burst command
//               aux_abort                        - stop issuing current burst
//               aux_rdata/aux_rvalid             - aux read return
//               aux_done/aux_busy                - burst status
//               starve/starve_clr                - sticky starvation flag
//               ram_addrb/ram_doutb              - RAM read port
//               vs_pulse, stat_*_words           - read statistics, only when
//                                                  FB_ARB_STATS_EN is defined
// Revision    : 1.0 - initial release
// ============================================================================
module fb_read_arbiter
  import fb_arb_pkg::*;
#(
  parameter int ADDR_W     = 17,
  parameter int DATA_W     = 16,
  parameter int FB_WORDS   = c_FB_WORDS_DEFAULT,
  parameter int RD_LAT     = 1,
  parameter int STARVE_MAX = 1024
) (
  input  logic              mclk,
  input  logic              rst_n,
  input  logic              disp_req,
  input  logic [ADDR_W-1:0] disp_addr,
  output logic [DATA_W-1:0] disp_rdata,
  output logic              disp_rvalid,
  input  logic              aux_cmd_valid,
  output logic              aux_cmd_ready,
  input  logic [ADDR_W-1:0] aux_cmd_addr,
  input  logic [ADDR_W-1:0] aux_cmd_len,
  input  logic              aux_abort,
  output logic [DATA_W-1:0] aux_rdata,
  output logic              aux_rvalid,
  output logic              aux_done,
  output logic              aux_busy,
  output logic              starve,
  input  logic              starve_clr,
`ifdef FB_ARB_STATS_EN
  input  logic              vs_pulse,
  output logic [19:0]       stat_aux_words,
  output logic [19:0]       stat_disp_words,
`endif
  output logic [ADDR_W-1:0] ram_addrb,
  input  logic [DATA_W-1:0] ram_doutb
);

  localparam logic [ADDR_W-1:0] c_ADDR_LAST = ADDR_W'(FB_WORDS - 1);
  localparam int                c_SCNT_W    = $clog2(STARVE_MAX + 1);
  localparam logic [c_SCNT_W-1:0] c_SCNT_MAX = c_SCNT_W'(STARVE_MAX);

  logic [1:0]          r_state, w_state_nxt;
  logic [ADDR_W-1:0]   r_aux_addr, r_aux_rem;
  logic                r_cmd_ready, r_busy, r_done, r_starve;
  logic [c_SCNT_W-1:0] r_scnt;
  logic [DATA_W-1:0]   r_disp_hold, r_aux_hold;
  logic                w_accept, w_len_zero, w_aux_issue, w_last_issue;
  logic                w_drain_exit, w_set_starve;
  own_t                w_tag_in, w_tag_out;
  logic                w_aux_pending;

  assign w_accept     = (r_state == c_ST_IDLE) && r_cmd_ready && aux_cmd_valid;
  assign w_len_zero   = (aux_cmd_len == '0);
  assign w_aux_issue  = (r_state == c_ST_RUN) && !disp_req;
  assign w_last_issue = w_aux_issue && (r_aux_rem == ADDR_W'(1));
  assign w_drain_exit = (r_state == c_ST_DRAIN) && !w_aux_pending;
  // Set one cycle early so the flag is visible once STARVE_MAX cycles elapsed
  assign w_set_starve = (r_state == c_ST_RUN) && disp_req &&
                        (r_scnt >= c_SCNT_MAX - c_SCNT_W'(1));

  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      c_ST_IDLE:  if (w_accept && !w_len_zero)       w_state_nxt = c_ST_RUN;
      c_ST_RUN:   if (w_last_issue || aux_abort)     w_state_nxt = c_ST_DRAIN;
      c_ST_DRAIN: if (!w_aux_pending)                w_state_nxt = c_ST_IDLE;
      default:                                       w_state_nxt = c_ST_IDLE;
    endcase
  end

  always_ff @(posedge mclk or negedge rst_n) begin
    if (!rst_n) begin
      r_state     <= c_ST_IDLE;
      r_cmd_ready <= 1'b0;
      r_busy      <= 1'b0;
      r_done      <= 1'b0;
      r_aux_addr  <= '0;
      r_aux_rem   <= '0;
      r_scnt      <= '0;
      r_starve    <= 1'b0;
      r_disp_hold <= '0;
      r_aux_hold  <= '0;
    end else begin
      r_state     <= w_state_nxt;
      r_cmd_ready <= (w_state_nxt == c_ST_IDLE);
      r_done      <= (w_accept && w_len_zero) || w_drain_exit;

      if (w_accept && !w_len_zero) r_busy <= 1'b1;
      else if (w_drain_exit)       r_busy <= 1'b0;

      if (w_accept) begin
        r_aux_addr <= aux_cmd_addr;
        r_aux_rem  <= aux_cmd_len;
      end else if (w_aux_issue) begin
        r_aux_addr <= (r_aux_addr == c_ADDR_LAST) ? '0 : r_aux_addr + ADDR_W'(1);
        r_aux_rem  <= r_aux_rem - ADDR_W'(1);
      end

      if ((r_state != c_ST_RUN) || w_aux_issue) r_scnt <= '0;
      else if (r_scnt != c_SCNT_MAX)            r_scnt <= r_scnt + c_SCNT_W'(1);

      if (w_set_starve)    r_starve <= 1'b1;
      else if (starve_clr) r_starve <= 1'b0;

      if (disp_rvalid) r_disp_hold <= ram_doutb;
      if (aux_rvalid)  r_aux_hold  <= ram_doutb;
    end
  end

  // Display always owns the port when requesting; aux address holds otherwise
  assign ram_addrb = disp_req ? disp_addr :
                     (r_state == c_ST_RUN) ? r_aux_addr : '0;

  assign w_tag_in = disp_req ? OWN_DISP : (w_aux_issue ? OWN_AUX : OWN_NONE);

  fb_arb_tag_pipe #(
    .RD_LAT (RD_LAT)
  ) u_tag_pipe (
    .mclk        (mclk),
    .rst_n       (rst_n),
    .tag_in      (w_tag_in),
    .tag_out     (w_tag_out),
    .aux_pending (w_aux_pending)
  );

  assign disp_rvalid   = (w_tag_out == OWN_DISP);
  assign aux_rvalid    = (w_tag_out == OWN_AUX);
  assign disp_rdata    = disp_rvalid ? ram_doutb : r_disp_hold;
  assign aux_rdata     = aux_rvalid  ? ram_doutb : r_aux_hold;
  assign aux_cmd_ready = r_cmd_ready;
  assign aux_busy      = r_busy;
  assign aux_done      = r_done;
  assign starve        = r_starve;

`ifdef FB_ARB_STATS_EN
  logic [19:0] r_cnt_aux, r_cnt_disp, r_stat_aux, r_stat_disp;

  // A read issued in the vs_pulse cycle belongs to the new frame
  always_ff @(posedge mclk or negedge rst_n) begin
    if (!rst_n) begin
      r_cnt_aux   <= '0;
      r_cnt_disp  <= '0;
      r_stat_aux  <= '0;
      r_stat_disp <= '0;
    end else if (vs_pulse) begin
      r_stat_aux  <= r_cnt_aux;
      r_stat_disp <= r_cnt_disp;
      r_cnt_aux   <= {19'd0, w_aux_issue};
      r_cnt_disp  <= {19'd0, disp_req};
    end else begin
      r_cnt_aux   <= r_cnt_aux  + {19'd0, w_aux_issue};
      r_cnt_disp  <= r_cnt_disp + {19'd0, disp_req};
    end
  end

  assign stat_aux_words  = r_stat_aux;
  assign stat_disp_words = r_stat_disp;
`endif

endmodule
`default_nettype wire

// File: tb/tb_fb_read_arbiter.sv
`default_nettype none
// ============================================================================
// Module      : tb_fb_read_arbiter
// Description : Directed self-checking bench for fb_read_arbiter with a
//               one-cycle RAM model whose data equals the low address bits.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_fb_read_arbiter;

  logic        mclk = 1'b0;
  logic        rst_n = 1'b0;
  logic        disp_req = 1'b0;
  logic [16:0] disp_addr = '0;
  logic [15:0] disp_rdata;
  logic        disp_rvalid;
  logic        aux_cmd_valid = 1'b0;
  logic        aux_cmd_ready;
  logic [16:0] aux_cmd_addr = '0;
  logic [16:0] aux_cmd_len = '0;
  logic        aux_abort = 1'b0;
  logic [15:0] aux_rdata;
  logic        aux_rvalid;
  logic        aux_done;
  logic        aux_busy;
  logic        starve;
  logic        starve_clr = 1'b0;
  logic [16:0] ram_addrb;
  logic [15:0] ram_doutb = '0;

  int n_assert = 0;
  int n_fail   = 0;

  logic [15:0] aux_d[$];
  int          aux_t[$];
  int          done_n, done_t, busy_fall_t, starve_t, disp_bad;

  fb_read_arbiter #(
    .ADDR_W     (17),
    .DATA_W     (16),
    .FB_WORDS   (76800),
    .RD_LAT     (1),
    .STARVE_MAX (16)
  ) dut (
    .mclk          (mclk),
    .rst_n         (rst_n),
    .disp_req      (disp_req),
    .disp_addr     (disp_addr),
    .disp_rdata    (disp_rdata),
    .disp_rvalid   (disp_rvalid),
    .aux_cmd_valid (aux_cmd_valid),
    .aux_cmd_ready (aux_cmd_ready),
    .aux_cmd_addr  (aux_cmd_addr),
    .aux_cmd_len   (aux_cmd_len),
    .aux_abort     (aux_abort),
    .aux_rdata     (aux_rdata),
    .aux_rvalid    (aux_rvalid),
    .aux_done      (aux_done),
    .aux_busy      (aux_busy),
    .starve        (starve),
    .starve_clr    (starve_clr),
    .ram_addrb     (ram_addrb),
    .ram_doutb     (ram_doutb)
  );

  always #5 mclk = ~mclk;

  // Synchronous RAM, one cycle latency, data = address
  always @(posedge mclk) ram_doutb <= ram_addrb[15:0];

  initial begin
    #2_000_000;
    $display("FAIL timeout: simulation did not finish (observed running, required finished)");
    $fatal(1);
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge mclk);
    #1;
  endtask

  task automatic send_cmd(input logic [16:0] a, input logic [16:0] l);
    aux_cmd_valid = 1'b1;
    aux_cmd_addr  = a;
    aux_cmd_len   = l;
    tick();
    aux_cmd_valid = 1'b0;
  endtask

  // Drive disp_req/aux_abort from bit patterns for n cycles and record returns.
  // Index k+1 is the first sample after cycle k's clock edge.
  task automatic run(input int n, input logic [31:0] dpat, input logic [31:0] apat);
    aux_d.delete();
    aux_t.delete();
    done_n = 0; done_t = -1; busy_fall_t = -1; starve_t = -1; disp_bad = 0;
    for (int k = 0; k < n; k++) begin
      disp_req  = dpat[k];
      disp_addr = 17'(500 + k);
      aux_abort = apat[k];
      #1;
      if (dpat[k] && ram_addrb !== 17'(500 + k)) disp_bad++;
      tick();
      if (disp_rvalid !== dpat[k]) disp_bad++;
      else if (dpat[k] && disp_rdata !== 16'(500 + k)) disp_bad++;
      if (aux_rvalid === 1'b1) begin
        aux_d.push_back(aux_rdata);
        aux_t.push_back(k + 1);
      end
      if (aux_done === 1'b1) begin done_n++; done_t = k + 1; end
      if (aux_busy !== 1'b1 && busy_fall_t < 0) busy_fall_t = k + 1;
      if (starve === 1'b1 && starve_t < 0) starve_t = k + 1;
    end
    disp_req  = 1'b0;
    aux_abort = 1'b0;
  endtask

  // Aux returns must be a run of wrapped addresses a0.. at times t0, t0+dt, ...
  task automatic chk_aux_seq(input string tag, input int exp_n, input int a0,
                             input int t0, input int dt);
    int bad = 0;
    int a;
    chk({tag, "_count"}, aux_d.size(), exp_n);
    for (int i = 0; i < aux_d.size() && i < exp_n; i++) begin
      a = a0 + i;
      if (a >= 76800) a = a - 76800;
      if (aux_d[i] !== 16'(a) || aux_t[i] !== t0 + i * dt) bad++;
    end
    chk({tag, "_seq"}, bad, 0);
  endtask

  initial begin
    int n_dv, n_av, bad;

    // Reset state
    tick(); tick();
    chk("rst_flags", {26'd0, aux_cmd_ready, aux_busy, aux_done, disp_rvalid, aux_rvalid, starve}, 0);
    chk("rst_rdata", {disp_rdata, aux_rdata}, 0);
    chk("rst_addrb", ram_addrb, 0);
    rst_n = 1'b1;
    tick();
    chk("ready_after_rst", aux_cmd_ready, 1);

    // Display only: 640 consecutive reads
    n_dv = 0; n_av = 0; bad = 0;
    for (int i = 0; i <= 640; i++) begin
      disp_req  = (i < 640);
      disp_addr = 17'(i);
      tick();
      if (disp_rvalid === 1'b1) n_dv++;
      if (disp_rvalid !== (i < 640)) bad++;
      else if (i < 640 && disp_rdata !== 16'(i)) bad++;
      if (aux_rvalid !== 1'b0) n_av++;
    end
    disp_req = 1'b0;
    chk("disp_only_count", n_dv, 640);
    chk("disp_only_data", bad, 0);
    chk("disp_only_no_aux", n_av, 0);
    chk("disp_rdata_hold", disp_rdata, 639);

    // Aux burst in blanking
    send_cmd(17'd100, 17'd8);
    chk("blank_busy", aux_busy, 1);
    chk("blank_ready_low", aux_cmd_ready, 0);
    run(12, 32'h0, 32'h0);
    chk_aux_seq("blank", 8, 100, 1, 1);
    chk("blank_done_t", done_t, 9);
    chk("blank_done_n", done_n, 1);
    chk("blank_busy_fall", busy_fall_t, 9);
    chk("blank_ready_back", aux_cmd_ready, 1);
    chk("aux_rdata_hold", aux_rdata, 107);

    // Interleave with toggling display
    send_cmd(17'd10, 17'd4);
    run(12, 32'h0000_0555, 32'h0);
    chk_aux_seq("ilv", 4, 10, 2, 2);
    chk("ilv_disp", disp_bad, 0);
    chk("ilv_done_t", done_t, 9);

    // Address wrap at the end of the frame
    send_cmd(17'd76798, 17'd4);
    run(8, 32'h0, 32'h0);
    chk_aux_seq("wrap", 4, 76798, 1, 1);

    // Abort together with the second issue
    send_cmd(17'h200, 17'd10);
    run(8, 32'h0, 32'h2);
    chk_aux_seq("abort", 2, 32'h200, 1, 1);
    chk("abort_done_t", done_t, 3);
    chk("abort_done_n", done_n, 1);

    // Zero length: no read, done on the next cycle
    chk("len0_ready", aux_cmd_ready, 1);
    aux_cmd_valid = 1'b1;
    aux_cmd_addr  = 17'h300;
    aux_cmd_len   = 17'd0;
    #1;
    chk("len0_addrb", ram_addrb, 0);
    tick();
    aux_cmd_valid = 1'b0;
    chk("len0_done", {aux_done, aux_busy}, 2'b10);
    run(4, 32'h0, 32'h0);
    chk("len0_no_read", aux_d.size(), 0);
    chk("len0_done_once", done_n, 0);

    // Starvation: burst pending under continuous display
    send_cmd(17'h400, 17'd4);
    run(20, 32'hFFFF_FFFF, 32'h0);
    chk("starve_t", starve_t, 16);
    chk("starve_no_aux", aux_d.size(), 0);
    chk("starve_disp", disp_bad, 0);
    disp_req = 1'b1; starve_clr = 1'b1;
    tick();
    chk("starve_set_wins", starve, 1);
    disp_req = 1'b0;
    tick();
    chk("starve_cleared", starve, 0);
    chk("starve_busy", aux_busy, 1);

    // Reset in the middle of the burst, with an aux read in flight
    starve_clr = 1'b0;
    rst_n = 1'b0;
    #1;
    chk("midrst_flags", {26'd0, aux_cmd_ready, aux_busy, aux_done, disp_rvalid, aux_rvalid, starve}, 0);
    chk("midrst_rdata", {disp_rdata, aux_rdata}, 0);
    chk("midrst_addrb", ram_addrb, 0);
    tick(); tick();
    rst_n = 1'b1;
    run(6, 32'h0, 32'h0);
    chk("midrst_no_done", done_n, 0);
    chk("midrst_no_aux", aux_d.size(), 0);
    chk("midrst_ready", aux_cmd_ready, 1);

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
`default_nettype wire
